// File: rtl/div_seq_pkg.sv
// Shared state encoding and defaults for the sequential MIPS DIV/DIVU unit.
package div_seq_pkg;

   localparam int unsigned DIV_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_DIVZERO = 2'b01,
      S_ON      = 2'b10,
      S_END     = 2'b11
   } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// One radix-2 restoring iteration: shift {rem,dvd} left, subtract the divisor when it fits.
module div_seq_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] dvd_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] dvd_o,
   output logic             qbit_o
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   // rem_i < divisor_i always holds, so the borrow bit of diff is a valid compare result
   always_comb begin
      rem_sh = {rem_i, dvd_i[WIDTH-1]};
      diff   = rem_sh - {1'b0, divisor_i};
      qbit_o = ~diff[WIDTH];
      rem_o  = qbit_o ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      dvd_o  = {dvd_i[WIDTH-2:0], 1'b0};
   end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: FSM, operand/sign registers, sign fix and HI/LO result registers.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opa_i,
   input  logic [WIDTH-1:0]   opb_i,
   input  logic               annul_i,
   output logic               stall_div_o,
   output logic               ready_o,
   output logic [2*WIDTH-1:0] result_o,
   output logic               div_by_zero_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dsr_q, dsr_d;
   logic               sgnq_q, sgnq_d;
   logic               sgnr_q, sgnr_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               dbz_q, dbz_d;
   logic               stall;

   logic               sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   step_rem, step_dvd, step_quot;
   logic               step_qbit;

   div_seq_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .dvd_i     (dvd_q),
      .divisor_i (dsr_q),
      .rem_o     (step_rem),
      .dvd_o     (step_dvd),
      .qbit_o    (step_qbit)
   );

   always_comb begin
      sa        = signed_i & opa_i[WIDTH-1];
      sb        = signed_i & opb_i[WIDTH-1];
      mag_a     = sa ? ('0 - opa_i) : opa_i;
      mag_b     = sb ? ('0 - opb_i) : opb_i;
      step_quot = step_dvd | {{(WIDTH-1){1'b0}}, step_qbit};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dsr_d    = dsr_q;
      sgnq_d   = sgnq_q;
      sgnr_d   = sgnr_q;
      result_d = result_q;
      dbz_d    = dbz_q;
      stall    = 1'b0;
      if (annul_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  stall = 1'b1;
                  if (opb_i == '0) begin
                     state_d = S_DIVZERO;
                  end else begin
                     state_d = S_ON;
                     rem_d   = '0;
                     dvd_d   = mag_a;
                     dsr_d   = mag_b;
                     sgnq_d  = sa ^ sb;
                     sgnr_d  = sa;
                     cnt_d   = '0;
                  end
               end
            end
            S_DIVZERO: begin
               stall    = 1'b1;
               state_d  = S_END;
               result_d = '0;
               dbz_d    = 1'b1;
            end
            S_ON: begin
               stall = 1'b1;
               rem_d = step_rem;
               dvd_d = step_quot;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d  = S_END;
                  result_d = {sgnr_q ? ('0 - step_rem)  : step_rem,
                              sgnq_q ? ('0 - step_quot) : step_quot};
                  dbz_d    = 1'b0;
               end
            end
            S_END: begin
               if (!start_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dsr_q    <= '0;
         sgnq_q   <= 1'b0;
         sgnr_q   <= 1'b0;
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dsr_q    <= dsr_d;
         sgnq_q   <= sgnq_d;
         sgnr_q   <= sgnr_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
      end
   end

   // Stall is combinational so the stalled instruction advances on the edge leaving END
   assign stall_div_o   = stall & ~rst;
   assign ready_o       = (state_q == S_END);
   assign result_o      = result_q;
   assign div_by_zero_o = dbz_q;

endmodule
